// File: rtl/acc_datapath_p.sv
// Accumulator-machine datapath: fetch / indirect / execute sequencer with a valid/ack memory port.
// Optional feature macro: ACC_DP_OVF_FLAG_EN adds the sticky signed-overflow output o_ovf.
module acc_datapath_p #(
    parameter int                DWIDTH   = 16,
    parameter int                AWIDTH   = 12,
    parameter logic [AWIDTH-1:0] PC_RESET = '0
) (
    input  logic              clk,
    input  logic              i_clr_reg,
    input  logic              i_run,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [AWIDTH-1:0] o_addr,
    output logic [DWIDTH-1:0] o_wdata,
    input  logic [DWIDTH-1:0] i_rdata,
    input  logic              i_mem_ack,
    output logic [DWIDTH-1:0] o_ac,
    output logic              o_e,
    output logic [AWIDTH-1:0] o_pc,
    output logic              o_retire,
    output logic              o_halt
`ifdef ACC_DP_OVF_FLAG_EN
    ,
    output logic              o_ovf
`endif
);

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, INDIR, MEM_RD, MEM_WR, EXEC, HALT
    } state_e;

    typedef enum logic [2:0] {
        OP_AND, OP_ADD, OP_LDA, OP_STA, OP_BUN, OP_BSA, OP_ISZ, OP_REG
    } opcode_e;

    state_e            state;
    logic [DWIDTH-1:0] ir;
    logic [DWIDTH-1:0] dr;
    logic [AWIDTH-1:0] ar;
    logic              ind;

    opcode_e           op;
    logic [AWIDTH-1:0] addr_field;
    logic [AWIDTH-1:0] pc_inc;
    logic [DWIDTH-1:0] dr_inc;
    logic [DWIDTH:0]   add_sum;

    assign op         = opcode_e'(ir[DWIDTH-2:AWIDTH]);
    assign addr_field = ir[AWIDTH-1:0];
    assign pc_inc     = o_pc + AWIDTH'(1);
    assign dr_inc     = dr + DWIDTH'(1);
    assign add_sum    = {1'b0, o_ac} + {1'b0, dr};

`ifdef ACC_DP_OVF_FLAG_EN
    logic add_ovf;
    assign add_ovf = (o_ac[DWIDTH-1] == dr[DWIDTH-1]) && (add_sum[DWIDTH-1] != o_ac[DWIDTH-1]);
`endif

    // Where a memory-reference op goes once its effective address is known.
    function automatic state_e route(input opcode_e opc);
        case (opc)
            OP_BUN:         return EXEC;
            OP_STA, OP_BSA: return MEM_WR;
            default:        return MEM_RD;
        endcase
    endfunction

    // Each memory state first raises o_mem_req, then completes on ack; req is therefore
    // always low for at least one cycle between transfers.
    always_ff @(posedge clk) begin
        if (i_clr_reg) begin
            state     <= IDLE;
            o_ac      <= '0;
            o_e       <= 1'b0;
            ir        <= '0;
            dr        <= '0;
            ar        <= '0;
            ind       <= 1'b0;
            o_pc      <= PC_RESET;
            o_mem_req <= 1'b0;
            o_mem_we  <= 1'b0;
            o_addr    <= '0;
            o_wdata   <= '0;
            o_retire  <= 1'b0;
            o_halt    <= 1'b0;
`ifdef ACC_DP_OVF_FLAG_EN
            o_ovf     <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking defaults first; a later assignment in the same block wins, so
            // o_retire can only ever be a one-cycle pulse.
            o_retire <= 1'b0;
            case (state)
                IDLE: if (i_run && !o_halt) state <= FETCH;

                FETCH: begin
                    if (!o_mem_req) begin
                        o_mem_req <= 1'b1;
                        o_mem_we  <= 1'b0;
                        o_addr    <= o_pc;
                    end else if (i_mem_ack) begin
                        o_mem_req <= 1'b0;
                        ir        <= i_rdata;
                        o_pc      <= pc_inc;
                        state     <= DECODE;
                    end
                end

                DECODE: begin
                    ind <= ir[DWIDTH-1];
                    if (op == OP_REG) begin
                        state <= EXEC;
                    end else if (ir[DWIDTH-1]) begin
                        state <= INDIR;
                    end else begin
                        ar    <= addr_field;
                        state <= route(op);
                    end
                end

                INDIR: begin
                    if (!o_mem_req) begin
                        o_mem_req <= 1'b1;
                        o_mem_we  <= 1'b0;
                        o_addr    <= addr_field;
                    end else if (i_mem_ack) begin
                        o_mem_req <= 1'b0;
                        ar        <= i_rdata[AWIDTH-1:0];
                        state     <= route(op);
                    end
                end

                MEM_RD: begin
                    if (!o_mem_req) begin
                        o_mem_req <= 1'b1;
                        o_mem_we  <= 1'b0;
                        o_addr    <= ar;
                    end else if (i_mem_ack) begin
                        o_mem_req <= 1'b0;
                        dr        <= i_rdata;
                        state     <= EXEC;
                    end
                end

                MEM_WR: begin
                    if (!o_mem_req) begin
                        o_mem_req <= 1'b1;
                        o_mem_we  <= 1'b1;
                        o_addr    <= ar;
                        case (op)
                            OP_STA:  o_wdata <= o_ac;
                            OP_BSA:  o_wdata <= DWIDTH'(o_pc);
                            default: o_wdata <= dr;
                        endcase
                    end else if (i_mem_ack) begin
                        o_mem_req <= 1'b0;
                        o_mem_we  <= 1'b0;
                        if (op == OP_BSA) o_pc <= ar + AWIDTH'(1);
                        o_retire  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                EXEC: begin
                    o_retire <= 1'b1;
                    state    <= IDLE;
                    if (op == OP_REG) begin
                        // Register reference: only the highest set bit acts; I=1 is an I/O no-op.
                        if (!ind) begin
                            if (ir[11])      o_ac <= '0;
                            else if (ir[10]) begin
                                o_e <= 1'b0;
`ifdef ACC_DP_OVF_FLAG_EN
                                o_ovf <= 1'b0;
`endif
                            end
                            else if (ir[9])  o_ac <= ~o_ac;
                            else if (ir[8])  o_e <= ~o_e;
                            else if (ir[7])  {o_ac, o_e} <= {o_e, o_ac};
                            else if (ir[6])  {o_e, o_ac} <= {o_ac, o_e};
                            else if (ir[5])  o_ac <= o_ac + DWIDTH'(1);
                            else if (ir[4])  begin if (!o_ac[DWIDTH-1]) o_pc <= pc_inc; end
                            else if (ir[3])  begin if (o_ac[DWIDTH-1]) o_pc <= pc_inc; end
                            else if (ir[2])  begin if (o_ac == '0) o_pc <= pc_inc; end
                            else if (ir[1])  begin if (!o_e) o_pc <= pc_inc; end
                            else if (ir[0])  begin
                                o_halt <= 1'b1;
                                state  <= HALT;
                            end
                        end
                    end else begin
                        case (op)
                            OP_AND: o_ac <= o_ac & dr;
                            OP_ADD: begin
                                {o_e, o_ac} <= add_sum;
`ifdef ACC_DP_OVF_FLAG_EN
                                if (add_ovf) o_ovf <= 1'b1;
`endif
                            end
                            OP_LDA: o_ac <= dr;
                            OP_BUN: o_pc <= ar;
                            OP_ISZ: begin
                                dr       <= dr_inc;
                                if (dr_inc == '0) o_pc <= pc_inc;
                                o_retire <= 1'b0;
                                state    <= MEM_WR;
                            end
                            default: ;
                        endcase
                    end
                end

                HALT: ;

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_datapath_p.sv
// Bench for acc_datapath_p: vector table, hand-written corner sequences and a random
// program checked against an instruction-level reference model.
module tb_acc_datapath_p;

    logic        clk = 1'b0;
    logic        i_clr_reg;
    logic        i_run;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [11:0] o_addr;
    logic [15:0] o_wdata;
    logic [15:0] i_rdata;
    logic        i_mem_ack;
    logic [15:0] o_ac;
    logic        o_e;
    logic [11:0] o_pc;
    logic        o_retire;
    logic        o_halt;
`ifdef ACC_DP_OVF_FLAG_EN
    logic        o_ovf;
`endif

    acc_datapath_p #(.DWIDTH(16), .AWIDTH(12), .PC_RESET(12'h000)) dut (
        .clk       (clk),
        .i_clr_reg (i_clr_reg),
        .i_run     (i_run),
        .o_mem_req (o_mem_req),
        .o_mem_we  (o_mem_we),
        .o_addr    (o_addr),
        .o_wdata   (o_wdata),
        .i_rdata   (i_rdata),
        .i_mem_ack (i_mem_ack),
        .o_ac      (o_ac),
        .o_e       (o_e),
        .o_pc      (o_pc),
        .o_retire  (o_retire),
        .o_halt    (o_halt)
`ifdef ACC_DP_OVF_FLAG_EN
        ,
        .o_ovf     (o_ovf)
`endif
    );

    initial forever #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- memory model (acks on the falling edge) ----------------
    logic [15:0] mem [4096];
    int          ack_delay  = 0;
    bit          rand_delay = 1'b0;
    bit          busy       = 1'b0;
    int          wait_cnt, cur_delay;
    logic [11:0] st_addr;
    logic        st_we;
    logic [15:0] st_wdata;
    int          stab_err = 0;
    int          last_req_cycles = 0;
    bit          wr_seen = 1'b0;
    logic [11:0] wr_addr;
    logic [15:0] wr_data;

    initial begin : mem_model
        i_mem_ack = 1'b0;
        i_rdata   = '0;
        forever begin
            @(negedge clk);
            i_mem_ack = 1'b0;
            if (!o_mem_req) begin
                busy = 1'b0;
            end else begin
                if (!busy) begin
                    busy      = 1'b1;
                    wait_cnt  = 0;
                    cur_delay = rand_delay ? int'($urandom_range(0, 3)) : ack_delay;
                    st_addr   = o_addr;
                    st_we     = o_mem_we;
                    st_wdata  = o_wdata;
                end else if (o_addr !== st_addr || o_mem_we !== st_we ||
                             (st_we && o_wdata !== st_wdata)) begin
                    stab_err++;
                end
                wait_cnt++;
                if (wait_cnt > cur_delay) begin
                    i_mem_ack       = 1'b1;
                    busy            = 1'b0;
                    last_req_cycles = wait_cnt;
                    if (o_mem_we) begin
                        mem[o_addr] = o_wdata;
                        wr_seen     = 1'b1;
                        wr_addr     = o_addr;
                        wr_data     = o_wdata;
                    end else begin
                        i_rdata = mem[o_addr];
                    end
                end
            end
        end
    end

    // ---------------- instruction-level reference model ----------------
    logic [15:0] ref_mem [4096];
    logic [15:0] r_ac;
    logic        r_e, r_halt, r_ovf;
    logic [11:0] r_pc;

    task automatic ref_reg_op(input int b);
        logic t;
        case (b)
            11: r_ac = 16'h0000;
            10: begin r_e = 1'b0; r_ovf = 1'b0; end
            9:  r_ac = ~r_ac;
            8:  r_e = ~r_e;
            7:  begin t = r_ac[0]; r_ac = {r_e, r_ac[15:1]}; r_e = t; end
            6:  begin t = r_ac[15]; r_ac = {r_ac[14:0], r_e}; r_e = t; end
            5:  r_ac = r_ac + 16'd1;
            4:  if (r_ac[15] == 1'b0) r_pc = r_pc + 12'd1;
            3:  if (r_ac[15] == 1'b1) r_pc = r_pc + 12'd1;
            2:  if (r_ac == 16'h0000) r_pc = r_pc + 12'd1;
            1:  if (r_e == 1'b0) r_pc = r_pc + 12'd1;
            default: r_halt = 1'b1;
        endcase
    endtask

    task automatic ref_step(output bit wrote, output logic [11:0] wa, output logic [15:0] wd);
        logic [15:0] inst, v;
        logic [11:0] ea;
        int          op, u, sa;
        bit          done;
        wrote = 1'b0;
        wa    = '0;
        wd    = '0;
        done  = 1'b0;
        inst  = ref_mem[r_pc];
        r_pc  = r_pc + 12'd1;
        op    = int'(inst[14:12]);
        if (op == 7) begin
            if (!inst[15]) begin
                for (int b = 11; b >= 0; b--) begin
                    if (inst[b] && !done) begin
                        ref_reg_op(b);
                        done = 1'b1;
                    end
                end
            end
        end else begin
            ea = inst[15] ? ref_mem[inst[11:0]][11:0] : inst[11:0];
            v  = ref_mem[ea];
            case (op)
                0: r_ac = r_ac & v;
                1: begin
                    u  = int'(r_ac) + int'(v);
                    sa = int'($signed(r_ac)) + int'($signed(v));
                    if (sa > 32767 || sa < -32768) r_ovf = 1'b1;
                    r_e  = (u > 65535);
                    r_ac = u[15:0];
                end
                2: r_ac = v;
                3: begin wrote = 1'b1; wa = ea; wd = r_ac; end
                4: r_pc = ea;
                5: begin wrote = 1'b1; wa = ea; wd = {4'h0, r_pc}; r_pc = ea + 12'd1; end
                default: begin
                    wrote = 1'b1; wa = ea; wd = v + 16'd1;
                    if (wd == 16'h0000) r_pc = r_pc + 12'd1;
                end
            endcase
            if (wrote) ref_mem[wa] = wd;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_run     = 1'b0;
        i_clr_reg = 1'b1;
        @(negedge clk);
        i_clr_reg = 1'b0;
    endtask

    task automatic wait_retire(input string name, input int budget);
        bit found = 1'b0;
        for (int n = 0; n < budget && !found; n++) begin
            @(negedge clk);
            if (o_retire) found = 1'b1;
        end
        check(name, found, 1);
    endtask

    task automatic run_until_halt(input string name, input int budget);
        bit found = 1'b0;
        i_run = 1'b1;
        for (int n = 0; n < budget && !found; n++) begin
            @(negedge clk);
            if (o_halt) found = 1'b1;
        end
        check(name, found, 1);
    endtask

    typedef struct {
        logic [15:0] instr;
        logic [15:0] operand;
        logic [15:0] ac0;
        logic        e0;
        logic [15:0] exp_ac;
        logic        exp_e;
        logic [11:0] exp_pc;
    } vec_t;

    vec_t vecs[20];

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit          wrote;
        logic [11:0] wa;
        logic [15:0] wd;
        int          cnt_req, cnt_ret, n_ret, bad0;

        // instr, operand@0x200, AC0, E0, expected AC, E, PC after the trailing HLT
        vecs[0]  = '{16'h1200, 16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 12'h004};
        vecs[1]  = '{16'h1200, 16'h4321, 16'h1234, 1'b1, 16'h5555, 1'b0, 12'h004};
        vecs[2]  = '{16'h0200, 16'h3C3C, 16'hF0F0, 1'b1, 16'h3030, 1'b1, 12'h004};
        vecs[3]  = '{16'h2200, 16'h1234, 16'h0000, 1'b0, 16'h1234, 1'b0, 12'h004};
        vecs[4]  = '{16'hA201, 16'h7777, 16'h0000, 1'b0, 16'h7777, 1'b0, 12'h004};
        vecs[5]  = '{16'h7200, 16'h0000, 16'h0F0F, 1'b0, 16'hF0F0, 1'b0, 12'h004};
        vecs[6]  = '{16'h7100, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 12'h004};
        vecs[7]  = '{16'h7080, 16'h0000, 16'h0001, 1'b0, 16'h0000, 1'b1, 12'h004};
        vecs[8]  = '{16'h7080, 16'h0000, 16'h0000, 1'b1, 16'h8000, 1'b0, 12'h004};
        vecs[9]  = '{16'h7040, 16'h0000, 16'h8001, 1'b0, 16'h0002, 1'b1, 12'h004};
        vecs[10] = '{16'h7020, 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 12'h004};
        vecs[11] = '{16'h7010, 16'h0000, 16'h0001, 1'b0, 16'h0001, 1'b0, 12'h005};
        vecs[12] = '{16'h7008, 16'h0000, 16'h0001, 1'b0, 16'h0001, 1'b0, 12'h004};
        vecs[13] = '{16'h7004, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 12'h005};
        vecs[14] = '{16'h7002, 16'h0000, 16'h1111, 1'b1, 16'h1111, 1'b1, 12'h004};
        vecs[15] = '{16'h7C00, 16'h0000, 16'h1234, 1'b1, 16'h0000, 1'b1, 12'h004};
        vecs[16] = '{16'h7000, 16'h0000, 16'hABCD, 1'b1, 16'hABCD, 1'b1, 12'h004};
        vecs[17] = '{16'hF800, 16'h0000, 16'hABCD, 1'b0, 16'hABCD, 1'b0, 12'h004};
        vecs[18] = '{16'h4006, 16'h0000, 16'h0042, 1'b0, 16'h0042, 1'b0, 12'h007};
        vecs[19] = '{16'h7003, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 12'h005};

        i_clr_reg = 1'b1;
        i_run     = 1'b0;
        clear_mem();
        repeat (2) @(negedge clk);
        i_clr_reg = 1'b0;
        check("rst_ac", o_ac, 16'h0000);
        check("rst_e", o_e, 1'b0);
        check("rst_pc", o_pc, 12'h000);
        check("rst_req", o_mem_req, 1'b0);
        check("rst_halt", o_halt, 1'b0);
        check("rst_retire", o_retire, 1'b0);
`ifdef ACC_DP_OVF_FLAG_EN
        check("rst_ovf", o_ovf, 1'b0);
`endif

        // LDA: exactly one retire, then quiet once run drops
        clear_mem();
        mem[12'h000] = 16'h2010;
        mem[12'h010] = 16'h1234;
        do_reset();
        i_run = 1'b1;
        wait_retire("lda_retire", 100);
        i_run = 1'b0;
        check("lda_ac", o_ac, 16'h1234);
        check("lda_pc", o_pc, 12'h001);
        cnt_req = 0;
        cnt_ret = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_mem_req) cnt_req++;
            if (o_retire) cnt_ret++;
        end
        check("lda_quiet_req", cnt_req, 0);
        check("lda_quiet_retire", cnt_ret, 0);

        // Reset in the middle of an open transaction
        clear_mem();
        mem[12'h000] = 16'h2010;
        mem[12'h010] = 16'hBEEF;
        do_reset();
        i_run = 1'b1;
        wait_retire("act_retire", 100);
        check("act_ac", o_ac, 16'hBEEF);
        ack_delay = 10;
        begin
            bit seen = 1'b0;
            for (int n = 0; n < 20 && !seen; n++) begin
                @(negedge clk);
                if (o_mem_req) seen = 1'b1;
            end
            check("act_req_open", seen, 1);
        end
        i_clr_reg = 1'b1;
        i_run     = 1'b0;
        @(negedge clk);
        i_clr_reg = 1'b0;
        check("midrst_req", o_mem_req, 1'b0);
        check("midrst_ac", o_ac, 16'h0000);
        check("midrst_e", o_e, 1'b0);
        check("midrst_pc", o_pc, 12'h000);
        check("midrst_halt", o_halt, 1'b0);
        check("midrst_retire", o_retire, 1'b0);
        ack_delay = 0;

        // Vector table
        for (int i = 0; i < 20; i++) begin
            clear_mem();
            mem[12'h000] = 16'h2100;
            mem[12'h100] = vecs[i].ac0;
            mem[12'h001] = vecs[i].e0 ? 16'h7100 : 16'h7400;
            mem[12'h002] = vecs[i].instr;
            for (int a = 3; a < 8; a++) mem[a] = 16'h7001;
            mem[12'h200] = vecs[i].operand;
            mem[12'h201] = 16'h0200;
            do_reset();
            run_until_halt($sformatf("vec%0d_halt", i), 400);
            i_run = 1'b0;
            check($sformatf("vec%0d_ac", i), o_ac, vecs[i].exp_ac);
            check($sformatf("vec%0d_e", i), o_e, vecs[i].exp_e);
            check($sformatf("vec%0d_pc", i), o_pc, vecs[i].exp_pc);
        end

`ifdef ACC_DP_OVF_FLAG_EN
        clear_mem();
        mem[12'h000] = 16'h2010;
        mem[12'h010] = 16'h7FFF;
        mem[12'h001] = 16'h1011;
        mem[12'h011] = 16'h0001;
        mem[12'h002] = 16'h7400;
        mem[12'h003] = 16'h7001;
        do_reset();
        i_run = 1'b1;
        wait_retire("ovf_lda", 100);
        wait_retire("ovf_add", 100);
        check("ovf_ac", o_ac, 16'h8000);
        check("ovf_set", o_ovf, 1'b1);
        wait_retire("ovf_cle", 100);
        check("ovf_clear", o_ovf, 1'b0);
        i_run = 1'b0;
`endif

        // STA indirect with a slow ack: request must hold steady
        clear_mem();
        mem[12'h000] = 16'h2010;
        mem[12'h010] = 16'h5A5A;
        mem[12'h001] = 16'hB020;
        mem[12'h020] = 16'h0040;
        do_reset();
        ack_delay = 5;
        stab_err  = 0;
        wr_seen   = 1'b0;
        i_run     = 1'b1;
        wait_retire("sta_lda", 200);
        wait_retire("sta_retire", 200);
        i_run = 1'b0;
        check("sta_wr_seen", wr_seen, 1'b1);
        check("sta_wr_addr", wr_addr, 12'h040);
        check("sta_wr_data", wr_data, 16'h5A5A);
        check("sta_mem", mem[12'h040], 16'h5A5A);
        check("sta_req_cycles", last_req_cycles, 6);
        check("sta_stable", stab_err, 0);
        ack_delay = 0;

        // ISZ with wrap (skip) and without
        clear_mem();
        mem[12'h000] = 16'h6030;
        mem[12'h001] = 16'h7001;
        mem[12'h002] = 16'h6031;
        mem[12'h003] = 16'h7001;
        mem[12'h030] = 16'hFFFF;
        mem[12'h031] = 16'h0005;
        ack_delay = 1;
        do_reset();
        i_run = 1'b1;
        wait_retire("isz0_retire", 200);
        check("isz0_pc", o_pc, 12'h002);
        check("isz0_wr_addr", wr_addr, 12'h030);
        check("isz0_wr_data", wr_data, 16'h0000);
        wait_retire("isz1_retire", 200);
        check("isz1_pc", o_pc, 12'h003);
        check("isz1_wr_addr", wr_addr, 12'h031);
        check("isz1_wr_data", wr_data, 16'h0006);
        run_until_halt("isz_halt", 200);
        check("isz_halt_pc", o_pc, 12'h004);
        ack_delay = 0;

        // CIL then HLT; halted core stays silent while run stays high
        clear_mem();
        mem[12'h000] = 16'h2010;
        mem[12'h010] = 16'h8001;
        mem[12'h001] = 16'h7040;
        mem[12'h002] = 16'h7001;
        do_reset();
        run_until_halt("hlt_reach", 200);
        check("hlt_ac", o_ac, 16'h0002);
        check("hlt_e", o_e, 1'b1);
        check("hlt_pc", o_pc, 12'h003);
        cnt_req = 0;
        cnt_ret = 0;
        repeat (30) begin
            @(negedge clk);
            if (o_mem_req) cnt_req++;
            if (o_retire) cnt_ret++;
        end
        check("hlt_no_req", cnt_req, 0);
        check("hlt_no_retire", cnt_ret, 0);
        check("hlt_sticky", o_halt, 1'b1);
        do_reset();
        check("hlt_rst_halt", o_halt, 1'b0);
        check("hlt_rst_pc", o_pc, 12'h000);

        // Random program against the reference model
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = 16'($urandom);
            ref_mem[i] = mem[i];
        end
        r_ac = '0; r_e = 1'b0; r_pc = '0; r_halt = 1'b0; r_ovf = 1'b0;
        wr_seen    = 1'b0;
        rand_delay = 1'b1;
        n_ret      = 0;
        bad0       = bad;
        i_run      = 1'b1;
        for (int cyc = 0; cyc < 30000 && n_ret < 300 && !r_halt && bad == bad0; cyc++) begin
            @(negedge clk);
            if (o_retire) begin
                ref_step(wrote, wa, wd);
                n_ret++;
                check("rnd_ac", o_ac, r_ac);
                check("rnd_e", o_e, r_e);
                check("rnd_pc", o_pc, r_pc);
                check("rnd_halt", o_halt, r_halt);
`ifdef ACC_DP_OVF_FLAG_EN
                check("rnd_ovf", o_ovf, r_ovf);
`endif
                check("rnd_wr_seen", wr_seen, wrote);
                if (wrote && wr_seen) begin
                    check("rnd_wr_addr", wr_addr, wa);
                    check("rnd_wr_data", wr_data, wd);
                end
                wr_seen = 1'b0;
            end
        end
        i_run      = 1'b0;
        rand_delay = 1'b0;
        check("rnd_progress", (n_ret >= 300) || r_halt || (bad != bad0), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/acc_datapath_p.md
Name: acc_datapath_p

Overview:
- Parametrised successor of the accumulator-machine datapath: self-sequencing fetch / indirect / execute core for the basic-computer ISA (AC, E, IR, DR, AR, PC, I).
- Generalised in data and address width.
- Talks to memory through a valid/ack handshake instead of bare strobes.
- Sits between the top-level control (run/halt) and the unified instruction/data memory.

Parameters:
- DWIDTH, 16, data/instruction width; must equal AWIDTH+4.
- AWIDTH, 12, address width; must be >= 12 (register-ref decode uses address-field bits 11..0).
- PC_RESET, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock, all state on rising edge.
- i_clr_reg  in  1  synchronous active-high reset.
- i_run  in  1  level; while high, a new instruction starts whenever the FSM is IDLE.
- o_mem_req  out  1  memory transaction valid.
- o_mem_we  out  1  1 = write, 0 = read; valid while o_mem_req.
- o_addr  out  AWIDTH  memory address; valid while o_mem_req.
- o_wdata  out  DWIDTH  write data; valid while o_mem_req && o_mem_we.
- i_rdata  in  DWIDTH  read data, sampled on the ack cycle.
- i_mem_ack  in  1  completes the current transaction.
- o_ac  out  DWIDTH  accumulator.
- o_e  out  1  E flip-flop.
- o_pc  out  AWIDTH  program counter.
- o_retire  out  1  one-cycle pulse when an instruction completes.
- o_halt  out  1  sticky; set by HLT.

Behaviour:
- Reset (synchronous, takes priority over everything): AC/DR/IR/AR=0, E=0, I=0, PC=PC_RESET, FSM=IDLE.
  - All outputs 0, except o_pc=PC_RESET.
  - Reset during an open transaction abandons it; o_mem_req is low the cycle after reset is sampled.
- Instruction format: [DWIDTH-1]=I, [DWIDTH-2:AWIDTH]=opcode (3 bits), [AWIDTH-1:0]=address field.
- Handshake:
  - o_mem_req, o_mem_we, o_addr and o_wdata are registered and held stable until the cycle in which i_mem_ack=1.
  - Exactly one transfer per ack; o_mem_req drops the next cycle.
  - i_mem_ack while o_mem_req=0 is ignored.
- FSM states: IDLE, FETCH, DECODE, INDIR, MEM_RD, MEM_WR, EXEC, HALT.
  - IDLE -> FETCH when i_run && !o_halt.
  - FETCH: read at PC. On ack: IR<=i_rdata; PC<=PC+1 (wraps modulo 2^AWIDTH); -> DECODE.
  - DECODE (1 cycle): I<=IR msb.
    - opcode 7: register-reference path -> EXEC.
    - I=1 with opcode != 7 -> INDIR.
    - Otherwise AR<=address field, then:
      - BUN -> EXEC.
      - STA, BSA -> MEM_WR.
      - Other memory-reference ops -> MEM_RD.
  - INDIR: read at IR address field. On ack: AR<=i_rdata[AWIDTH-1:0]; route as in DECODE.
  - MEM_RD: read at AR. On ack: DR<=i_rdata; -> EXEC.
  - EXEC: performs the operation (below), pulses o_retire, -> IDLE. ISZ instead goes -> MEM_WR, and retires after its write.
  - MEM_WR: write at AR. On ack: retire, -> IDLE.
- Memory-reference opcodes:
  - 0 AND: AC<=AC&DR.
  - 1 ADD: {E,AC}<=AC+DR, carry out to E.
  - 2 LDA: AC<=DR.
  - 3 STA: wdata=AC.
  - 4 BUN: PC<=AR.
  - 5 BSA: wdata = PC zero-extended to DWIDTH; on ack PC<=AR+1.
  - 6 ISZ: DR<=DR+1 in EXEC, wdata=DR+1; if DR+1==0 then PC<=PC+1.
- Register-reference (opcode 7, I=0): address-field bits 11..0 = CLA, CLE, CMA, CME, CIR, CIL, INC, SPA, SNA, SZA, SZE, HLT.
  - Only the highest-index set bit executes; no bits set = NOP.
  - CIR: {AC,E}<={E,AC} rotate right.
  - CIL: {E,AC}<={AC,E} rotate left.
  - SPA/SNA/SZA/SZE: PC<=PC+1 when AC msb==0 / AC msb==1 / AC==0 / E==0 respectively.
  - HLT: o_halt<=1, retire, -> HALT. HALT is left only by reset.
- Opcode 7 with I=1 (I/O): NOP, retires from EXEC.
- i_run deasserted mid-instruction: the current instruction completes; the FSM then stays in IDLE.

Optional Feature:
- Macro: ACC_DP_OVF_FLAG_EN.
- Defined:
  - Adds output o_ovf (1 bit, reset 0).
  - Sticky signed-overflow flag, set when ADD's operand signs match and the result sign differs.
  - Cleared by CLE.
- Undefined: port absent; ADD behaviour unchanged.

Test Plan:
All scenarios use DWIDTH=16, AWIDTH=12 and a memory model with a configurable ack delay.
- Reset after arbitrary activity -> next cycle AC=0, E=0, PC=0, o_mem_req=0, o_halt=0, o_retire=0.
- mem[0]=0x2010 (LDA 0x010), mem[0x010]=0x1234, i_run=1 -> one o_retire pulse; AC=0x1234, PC=1.
- AC=0xFFFF, instruction ADD with operand 0x0001 -> AC=0x0000, E=1. With ACC_DP_OVF_FLAG_EN, AC=0x7FFF + 0x0001 -> o_ovf=1.
- mem[0]=0xB020 (STA indirect), mem[0x020]=0x0040, AC=0x5A5A -> write transaction addr 0x040 with wdata 0x5A5A; ack delayed 5 cycles, addr/wdata stable throughout.
- ISZ at 0x030 with mem[0x030]=0xFFFF -> write of 0x0000 to 0x030; PC advances by 2.
- AC=0x8001, E=0, CIL (0x7040) -> AC=0x0002, E=1. Then HLT (0x7001) -> o_halt=1, no further o_mem_req while i_run stays high; reset clears o_halt.
